// File: rtl/uart_pkg.sv
// Shared types and register map for the UART receiver peripheral.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam logic [31:0] UART_RX_DATA   = 32'd0;
  localparam logic [31:0] UART_RX_STATUS = 32'd4;

  localparam int STAT_AVAIL     = 0;
  localparam int STAT_OVR       = 1;
  localparam int STAT_FERR      = 2;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/rx_fifo.sv
// Single-clock show-ahead FIFO for received bytes; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == (AW+1)'(0));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: oversampling bit FSM, receive FIFO and
// a two-register slave on the picorv32 native bus.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam int AW         = $clog2(FIFO_DEPTH);

  logic            sync1;
  logic            rx_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            frame_ok;
  logic            frame_err;

  logic            ack;
  logic [31:0]     rdata_reg;
  logic            ovr;
  logic            ferr;

  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;

  logic            req;
  logic            is_write;
  logic            sel_status;
  logic            pop;
  logic            clr_ovr;
  logic            clr_ferr;
  logic            ovr_set;
  logic [31:0]     status;
  logic            unused;

  assign unused = ^{mem_instr, mem_addr[31:3], mem_addr[1:0],
                    mem_wdata[31:3], mem_wdata[0]};

  assign mem_ready = enable ? ack : 1'bz;
  assign mem_rdata = enable ? rdata_reg : 32'bz;

  assign req        = enable & mem_valid & ~ack;
  assign is_write   = (mem_wstrb != 4'b0000);
  assign sel_status = (mem_addr[2] == UART_RX_STATUS[2]);
  assign pop        = req & ~is_write & ~sel_status & ~fifo_empty;
  assign clr_ovr    = req & is_write & sel_status & mem_wdata[STAT_OVR];
  assign clr_ferr   = req & is_write & sel_status & mem_wdata[STAT_FERR];
  assign ovr_set    = frame_ok & fifo_full & ~pop;

  // Status word assembly.
  always_comb begin
    status                            = 32'h0000_0000;
    status[STAT_AVAIL]                = ~fifo_empty;
    status[STAT_OVR]                  = ovr;
    status[STAT_FERR]                 = ferr;
    status[STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
  end

  // Two-flop synchronizer for the asynchronous line, idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serialIn;
      rx_s  <= sync1;
    end
  end

  // Bit sampler: start-bit qualify at mid-bit, then sample each bit centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= CW'(BIT_CYCLES / 2 - 1);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= ST_IDLE;
          end else begin
            cnt     <= CW'(BIT_CYCLES - 1);
            bit_idx <= 3'd0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= CW'(BIT_CYCLES - 1);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            frame_ok <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a long break is one error.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set   | (ovr  & ~clr_ovr);
      ferr <= frame_err | (ferr & ~clr_ferr);
    end
  end

  // Bus slave: one-cycle acknowledge with registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack       <= 1'b0;
      rdata_reg <= 32'h0000_0000;
    end else if (req) begin
      ack <= 1'b1;
      if (is_write) begin
        rdata_reg <= 32'h0000_0000;
      end else if (sel_status) begin
        rdata_reg <= status;
      end else if (fifo_empty) begin
        rdata_reg <= 32'h0000_0000;
      end else begin
        rdata_reg <= {24'h00_0000, fifo_dout};
      end
    end else begin
      ack <= 1'b0;
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (frame_ok),
    .pop   (pop),
    .din   (shreg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
